sub_bytes_pipe: RTL and testbench

//   Multi-lane, pipelined AES SubBytes engine. Applies the AES S-box to LANES

---
 rtl/sub_bytes_pipe.sv | 151 +++++++++++++++
 tb/tb_sub_bytes_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// rtl/sub_bytes_pipe.sv - multi-lane pipelined AES SubBytes engine (optional inverse table: SUB_BYTES_INV_SBOX_EN)
module sub_bytes_pipe #(
    parameter int LANES  = 16,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   data_out,
    output logic                 out_mode,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("sub_bytes_pipe: STAGES must be in 1..3");
    end
    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("sub_bytes_pipe: LANES must be in 1..16");
    end

    // The S-box is the GF(2^8) multiplicative inverse followed by an affine map;
    // expressing it arithmetically covers all 256 codes with no default path.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for nonzero a, and 0 maps to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] s;
        s = gf_inv(a);
        return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
    endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction
`endif

    logic [W-1:0]      lut_data;
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_mode;
    logic [W-1:0]      st_data [STAGES];
    logic [STAGES-1:0] st_adv;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_mode;
    logic [W-1:0]      up_data [STAGES];

    // Per-lane combinational lookup; lanes never interact.
    always_comb begin
        lut_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SUB_BYTES_INV_SBOX_EN
            lut_data[8*i +: 8] = in_mode ? inv_sbox(data_in[8*i +: 8])
                                         : fwd_sbox(data_in[8*i +: 8]);
`else
            lut_data[8*i +: 8] = fwd_sbox(data_in[8*i +: 8]);
`endif
        end
    end

    // Advance chain from the output back: a stage moves if it is empty or everything downstream moves.
    always_comb begin
        logic run;
        st_adv = '0;
        run    = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            run       = run || !st_valid[k];
            st_adv[k] = run;
        end
    end

    // Source feeding each stage: the lookup for stage 0, the previous stage otherwise.
    always_comb begin
        up_valid    = '0;
        up_mode     = '0;
        up_valid[0] = in_valid;
        up_mode[0]  = in_mode;
        up_data[0]  = lut_data;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = st_valid[k-1];
            up_mode[k]  = st_mode[k-1];
            up_data[k]  = st_data[k-1];
        end
    end

    // Stage registers; payload only loads with a valid transaction so bubbles keep old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            st_mode  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (st_adv[k]) begin
                    st_valid[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        st_mode[k] <= up_mode[k];
                        st_data[k] <= up_data[k];
                    end
                end
            end
        end
    end

    assign in_ready  = st_adv[0];
    assign out_valid = st_valid[STAGES-1];
    assign out_mode  = st_mode[STAGES-1];
    assign data_out  = st_data[STAGES-1];
    assign busy      = |st_valid;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb/tb_sub_bytes_pipe.sv - self-checking bench for sub_bytes_pipe
module tb_sub_bytes_pipe;

    localparam int STAGES = 2;
`ifdef SUB_BYTES_INV_SBOX_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         out_mode;
    logic         busy;

    logic         sw_valid;
    logic         sw_mode;
    logic         sw_ordy;
    logic [127:0] sw_din;
    logic [5:0]   sw_ir;
    logic [5:0]   sw_ov;
    logic [5:0]   sw_om;
    logic [5:0]   sw_busy;
    logic [127:0] sw_dout [6];

    int checks   = 0;
    int failures = 0;

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [128:0] exp_q [$];

    always #5 clk = ~clk;

    sub_bytes_pipe #(.LANES(16), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .out_mode(out_mode), .busy(busy)
    );

    for (genvar g = 0; g < 6; g++) begin : g_sw
        localparam int L = (g < 2) ? 1 : ((g < 4) ? 4 : 16);
        localparam int S = (g % 2 == 0) ? 1 : 3;
        logic [8*L-1:0] dout;
        sub_bytes_pipe #(.LANES(L), .STAGES(S)) u_dut (
            .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[g]),
            .in_mode(sw_mode), .data_in(sw_din[8*L-1:0]), .out_valid(sw_ov[g]),
            .out_ready(sw_ordy), .data_out(dout), .out_mode(sw_om[g]), .busy(sw_busy[g])
        );
        assign sw_dout[g] = 128'(dout);
    end

    // Reference: carry-less product reduced by the AES polynomial.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, r, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv;
            for (int i = 0; i < 8; i++)
                r[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ c[i];
            fwd_t[a] = r;
        end
        for (int a = 0; a < 256; a++) inv_t[fwd_t[a]] = 8'(a);
    endtask

    function automatic logic [127:0] m_xform(input logic [127:0] d, input logic md, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = (md && INV_EN) ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Samples handshakes and output just before the next edge, then steps one cycle.
    task automatic tick(output bit inf, output bit outf, output logic [127:0] od, output logic om);
        #1;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        od   = data_out;
        om   = out_mode;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; sw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        bit inf, outf; logic [127:0] od, d, e; logic om; int n;
        out_ready = 1'b0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (data_out !== 128'h0) begin failures++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (out_mode !== 1'b0) begin failures++; $display("FAIL reset_out_mode got=%b want=0", out_mode); end
        out_ready = 1'b1;
        d = rnd128(); d[31:0] = 32'h01ff5300;
        data_in = d; in_mode = 1'b0; in_valid = 1'b1;
        tick(inf, outf, od, om);
        in_valid = 1'b0;
        checks++; if (inf !== 1'b1) begin failures++; $display("FAIL first_accept got=%b want=1", inf); end
        n = 1;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (n != STAGES) begin failures++; $display("FAIL first_latency got=%0d want=%0d", n, STAGES); end
        checks++; if (data_out[31:0] !== 32'h7c16ed63) begin failures++; $display("FAIL first_lanes got=%h want=7c16ed63", data_out[31:0]); end
        e = m_xform(d, 1'b0, 16);
        checks++; if (data_out !== e) begin failures++; $display("FAIL first_word got=%h want=%h", data_out, e); end
        tick(inf, outf, od, om);
    endtask

    task automatic test_exhaustive();
        bit inf, outf; logic [127:0] od; logic om; logic [128:0] e;
        int sent, got, first_c, last_c;
        do_reset();
        out_ready = 1'b1; in_mode = 1'b0; sent = 0; got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && got < 16; c++) begin
            in_valid = (sent < 16);
            for (int i = 0; i < 16; i++) data_in[8*i +: 8] = 8'(16 * sent + i);
            tick(inf, outf, od, om);
            if (inf) begin exp_q.push_back({1'b0, m_xform(data_in, 1'b0, 16)}); sent++; end
            if (outf) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL exh_extra_output got=%h", od); end
                else begin
                    e = exp_q.pop_front();
                    if ({om, od} !== e) begin failures++; $display("FAIL exh_data txn=%0d got=%h want=%h", got, {om, od}, e); end
                end
                if (got == 5) begin checks++; if (od[23:16] !== 8'h00) begin failures++; $display("FAIL exh_52 got=%h want=00", od[23:16]); end end
                if (got == 12) begin checks++; if (od[79:72] !== 8'hdd) begin failures++; $display("FAIL exh_c9 got=%h want=dd", od[79:72]); end end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 16) begin failures++; $display("FAIL exh_count got=%0d want=16", got); end
        checks++; if (last_c - first_c != 15) begin failures++; $display("FAIL exh_throughput got=%0d want=15", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        bit inf, outf; logic [127:0] od, hold; logic om; logic [128:0] e; int acc, got;
        do_reset();
        out_ready = 1'b0; in_mode = 1'b0; acc = 0; got = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; data_in = rnd128();
            tick(inf, outf, od, om);
            if (inf) begin acc++; exp_q.push_back({1'b0, m_xform(data_in, 1'b0, 16)}); end
        end
        checks++; if (acc != STAGES) begin failures++; $display("FAIL bp_accepts got=%0d want=%0d", acc, STAGES); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        hold = data_out;
        for (int c = 0; c < 3; c++) begin
            tick(inf, outf, od, om);
            checks++; if (out_valid !== 1'b1 || data_out !== hold) begin failures++; $display("FAIL bp_stable got=%b/%h want=1/%h", out_valid, data_out, hold); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_accept got=%b want=1", in_ready); end
        for (int c = 0; c < 30 && (acc < 8 || exp_q.size() > 0); c++) begin
            in_valid = (acc < 8); data_in = rnd128();
            tick(inf, outf, od, om);
            if (inf) begin acc++; exp_q.push_back({1'b0, m_xform(data_in, 1'b0, 16)}); end
            if (outf) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_duplicate got=%h", od); end
                else begin
                    e = exp_q.pop_front();
                    if ({om, od} !== e) begin failures++; $display("FAIL bp_order got=%h want=%h", {om, od}, e); end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 8 || exp_q.size() != 0) begin failures++; $display("FAIL bp_drops got=%0d want=8", got); end
    endtask

    task automatic test_inverse();
        bit inf, outf; logic [127:0] od, d, ex; logic om; logic [128:0] e; int n, acc, got;
        do_reset();
        out_ready = 1'b1;
        d = rnd128(); d[23:0] = 24'h16ed63;
        data_in = d; in_mode = 1'b1; in_valid = 1'b1;
        tick(inf, outf, od, om);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        ex = m_xform(d, 1'b1, 16);
        if (INV_EN) ex[23:0] = 24'hff5300;
        checks++; if (data_out[23:0] !== ex[23:0]) begin failures++; $display("FAIL inv_lanes got=%h want=%h", data_out[23:0], ex[23:0]); end
        checks++; if (out_mode !== 1'b1) begin failures++; $display("FAIL inv_out_mode got=%b want=1", out_mode); end
        tick(inf, outf, od, om);
        acc = 0; got = 0;
        for (int c = 0; c < 30 && got < 10; c++) begin
            in_valid = (acc < 10); in_mode = acc[0]; data_in = rnd128();
            tick(inf, outf, od, om);
            if (inf) begin acc++; exp_q.push_back({in_mode, m_xform(data_in, in_mode, 16)}); end
            if (outf) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL alt_extra got=%h", od); end
                else begin
                    e = exp_q.pop_front();
                    if ({om, od} !== e) begin failures++; $display("FAIL alt_mode_data got=%h want=%h", {om, od}, e); end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 10) begin failures++; $display("FAIL alt_count got=%0d want=10", got); end
    endtask

    task automatic test_random();
        bit inf, outf, p_ov, p_fire; logic [127:0] od, p_od; logic om; logic [128:0] e; int got, acc;
        do_reset();
        acc = 0; got = 0; p_ov = 1'b0; p_fire = 1'b0; p_od = '0;
        for (int c = 0; c < 300; c++) begin
            if (p_ov && !p_fire) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== p_od) begin failures++; $display("FAIL rnd_hold got=%b/%h want=1/%h", out_valid, data_out, p_od); end
            end
            in_valid = (c < 260) && ($urandom_range(0, 99) < 60);
            in_mode = 1'($urandom); data_in = rnd128();
            out_ready = ($urandom_range(0, 99) < 50) || (c >= 260);
            p_ov = out_valid;
            tick(inf, outf, od, om);
            p_fire = outf; p_od = od;
            if (inf) begin acc++; exp_q.push_back({in_mode, m_xform(data_in, in_mode, 16)}); end
            if (outf) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_extra got=%h", od); end
                else begin
                    e = exp_q.pop_front();
                    if ({om, od} !== e) begin failures++; $display("FAIL rnd_data got=%h want=%h", {om, od}, e); end
                end
                got++;
            end
        end
        checks++; if (got != acc || exp_q.size() != 0) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", got, acc); end
    endtask

    task automatic test_midreset();
        bit inf, outf, seen; logic [127:0] od; logic om;
        do_reset();
        out_ready = 1'b0; in_mode = 1'b1;
        for (int c = 0; c < 5 && in_ready; c++) begin
            in_valid = 1'b1; data_in = rnd128();
            tick(inf, outf, od, om);
        end
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mr_full got=%b%b%b want=110", busy, out_valid, in_ready); end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mr_cleared got=%b%b want=00", out_valid, busy); end
        checks++; if (data_out !== 128'h0 || out_mode !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mr_regs got=%h/%b/%b want=0/0/1", data_out, out_mode, in_ready); end
        out_ready = 1'b1; seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(inf, outf, od, om);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mr_stale got=%b want=0", seen); end
    endtask

    task automatic test_sweep();
        int lat [6]; logic [127:0] got_d [6]; logic got_m [6];
        logic [127:0] ex; int L, S;
        do_reset();
        sw_ordy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sw_din = rnd128(); sw_mode = 1'($urandom); sw_valid = 1'b1;
            for (int g = 0; g < 6; g++) begin lat[g] = 0; got_d[g] = '0; got_m[g] = 1'b0; end
            #1;
            checks++; if (sw_ir !== 6'h3f) begin failures++; $display("FAIL sw_in_ready got=%b want=111111", sw_ir); end
            @(posedge clk); #1;
            sw_valid = 1'b0;
            for (int n = 1; n <= 6; n++) begin
                for (int g = 0; g < 6; g++)
                    if (sw_ov[g] && lat[g] == 0) begin lat[g] = n; got_d[g] = sw_dout[g]; got_m[g] = sw_om[g]; end
                @(posedge clk); #1;
            end
            for (int g = 0; g < 6; g++) begin
                L = (g < 2) ? 1 : ((g < 4) ? 4 : 16);
                S = (g % 2 == 0) ? 1 : 3;
                ex = m_xform(sw_din, sw_mode, L);
                checks++; if (lat[g] != S) begin failures++; $display("FAIL sw_latency L=%0d S=%0d got=%0d want=%0d", L, S, lat[g], S); end
                checks++; if (got_d[g] !== ex || got_m[g] !== sw_mode) begin failures++; $display("FAIL sw_data L=%0d S=%0d got=%h/%b want=%h/%b", L, S, got_d[g], got_m[g], ex, sw_mode); end
            end
        end
        checks++; if (sw_busy !== 6'h00) begin failures++; $display("FAIL sw_idle got=%b want=000000", sw_busy); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; data_in = '0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_mode = 1'b0; sw_din = '0; sw_ordy = 1'b1;
        build_tables();
        checks++; if (fwd_t[8'h53] !== 8'hed || inv_t[8'h00] !== 8'h52) begin failures++; $display("FAIL model_table got=%h/%h want=ed/52", fwd_t[8'h53], inv_t[8'h00]); end
        test_reset();
        test_exhaustive();
        test_backpressure();
        test_inverse();
        test_random();
        test_midreset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
